// File: rtl/multi_clock_gen_pkg.sv
// Shared types for the multi-channel clock generator: channel FSM states,
// the per-channel timing record and its validity rule.
package multi_clock_gen_pkg;

  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW
  } chan_state_t;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } chan_cfg_t;

  // A usable waveform needs at least one HIGH and one LOW cycle per period,
  // and a start delay shorter than one period.
  function automatic logic cfg_valid(input chan_cfg_t c);
    return (c.period >= CFG_W'(2)) && (c.high != '0) &&
           (c.high < c.period) && (c.phase < c.period);
  endfunction

endpackage

// File: rtl/clk_gen_channel.sv
// One divided-clock channel: IDLE/DELAY/HIGH/LOW down-counting FSM with
// pending and active timing registers; output is registered from next state.
module clk_gen_channel
  import multi_clock_gen_pkg::*;
#(
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5,
  parameter int DEF_PHASE  = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      enable,
  input  logic      wr,
  input  chan_cfg_t wr_cfg,
  output logic      clk_out,
  output logic      running
);

  localparam chan_cfg_t DEF_CFG = '{
    period: CFG_W'(DEF_PERIOD),
    high:   CFG_W'(DEF_HIGH),
    phase:  CFG_W'(DEF_PHASE)
  };

  chan_state_t      state_q, state_d;
  logic [CFG_W-1:0] cnt_q, cnt_d;
  chan_cfg_t        pend_q, pend_d;
  chan_cfg_t        act_q, act_d;

  // NOTE: every variable gets a default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    pend_d  = wr ? wr_cfg : pend_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    unique case (state_q)
      IDLE: begin
        act_d = pend_d;
        cnt_d = '0;
        if (enable) begin
          if (pend_d.phase == '0) begin
            state_d = HIGH;
            cnt_d   = pend_d.high;
          end else begin
            state_d = DELAY;
            cnt_d   = pend_d.phase;
          end
        end
      end
      DELAY: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CFG_W'(1)) begin
          state_d = HIGH;
          cnt_d   = act_q.high;
        end else begin
          cnt_d = cnt_q - CFG_W'(1);
        end
      end
      HIGH: begin
        // Enable is only honoured at the end of HIGH, so no runt pulse.
        if (cnt_q == CFG_W'(1)) begin
          if (enable) begin
            state_d = LOW;
            cnt_d   = act_q.period - act_q.high;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CFG_W'(1);
        end
      end
      LOW: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CFG_W'(1)) begin
          // Period boundary: a write landing on this very cycle still counts.
          act_d   = pend_d;
          state_d = HIGH;
          cnt_d   = pend_d.high;
        end else begin
          cnt_d = cnt_q - CFG_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: the timing registers are reset too, because after reset the
  // channel must run from the DEF_* values without any prior write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= DEF_CFG;
      act_q   <= DEF_CFG;
      clk_out <= 1'b0;
      running <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from
      // the same pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      clk_out <= (state_d == HIGH);
      running <= (state_d != IDLE);
    end
  end

endmodule

// File: rtl/multi_clock_gen.sv
// Multi-channel programmable clock/strobe generator: validates config writes,
// steers them to the addressed channel and reports rejected writes.
module multi_clock_gen
  import multi_clock_gen_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CW         = CFG_W,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5,
  parameter int DEF_PHASE  = 0,
  localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] enable,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [CW-1:0]  cfg_high,
  input  logic [CW-1:0]  cfg_phase,
  output logic           cfg_err,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] running
);

  chan_cfg_t wr_cfg;
  logic      wr_ok;

  always_comb begin
    wr_cfg = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
    wr_ok  = cfg_valid(wr_cfg) && (int'(cfg_ch) < NCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !wr_ok;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_gen_channel #(
      .DEF_PERIOD(DEF_PERIOD),
      .DEF_HIGH  (DEF_HIGH),
      .DEF_PHASE (DEF_PHASE)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable[g]),
      .wr     (cfg_wr && wr_ok && (cfg_ch == CHW'(g))),
      .wr_cfg (wr_cfg),
      .clk_out(clk_out[g]),
      .running(running[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Directed self-checking bench for multi_clock_gen (3 channels so that an
// out-of-range channel index can be exercised).
module tb_multi_clock_gen;

  localparam int NCH = 3;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] enable;
  logic           cfg_wr;
  logic [CHW-1:0] cfg_ch;
  logic [15:0]    cfg_period, cfg_high, cfg_phase;
  logic           cfg_err;
  logic [NCH-1:0] clk_out, running;

  int total = 0;
  int bad   = 0;
  int c0, c1, p0, h0;

  always #5 clk = ~clk;

  multi_clock_gen #(
    .NCH(NCH), .CW(16), .DEF_PERIOD(10), .DEF_HIGH(5), .DEF_PHASE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high),
    .cfg_phase(cfg_phase), .cfg_err(cfg_err), .clk_out(clk_out),
    .running(running)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Expected ch0 level, c0 edges after the first rising edge of its current pattern.
  function automatic logic exp0();
    if (c0 < 1) return 1'b0;
    return ((c0 - 1) % p0) < h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    c0++;
    c1++;
  endtask

  task automatic step0(input string tag);
    tick();
    check(tag, clk_out[0], exp0());
  endtask

  task automatic set_cfg(input logic [CHW-1:0] ch, input int p, input int h, input int d);
    cfg_wr     = 1'b1;
    cfg_ch     = ch;
    cfg_period = 16'(p);
    cfg_high   = 16'(h);
    cfg_phase  = 16'(d);
  endtask

  int bad_p[4]  = '{1, 6, 6, 6};
  int bad_h[4]  = '{1, 6, 3, 3};
  int bad_d[4]  = '{0, 0, 6, 0};
  int bad_ch[4] = '{0, 0, 0, 3};

  initial begin
    rst_n = 1'b0; enable = '0; cfg_wr = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    c0 = 0; c1 = 0; p0 = 10; h0 = 5;

    #12;
    check("rst_clk", clk_out, 0);
    check("rst_run", running, 0);
    check("rst_err", cfg_err, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("idle_clk", clk_out, 0);
    check("idle_run", running, 0);

    // Defaults on ch0: rise on the first edge, 5 high / 5 low.
    enable[0] = 1'b1; c0 = 0;
    for (int k = 0; k < 20; k++) begin
      step0("t1_ch0");
      check("t1_run0", running[0], 1);
      check("t1_ch1", clk_out[1], 0);
    end

    // Program idle ch1 with P=7 H=2 D=3, then start it.
    set_cfg(1, 7, 2, 3);
    step0("t2_ch0w");
    check("t2_err", cfg_err, 0);
    cfg_wr = 1'b0;
    enable[1] = 1'b1; c1 = 0;
    for (int k = 0; k < 20; k++) begin
      step0("t2_ch0");
      check("t2_ch1", clk_out[1], (c1 >= 4) && (((c1 - 4) % 7) < 2));
      check("t2_run1", running[1], 1);
    end
    enable[1] = 1'b0;       // ch1 is in LOW here
    step0("t2_ch0s");
    check("t2_stop_run1", running[1], 0);
    check("t2_stop_clk1", clk_out[1], 0);

    // Brief enable drop inside HIGH is cancelled.
    for (int i = 0; i < 20 && ((c0 - 1) % p0) != 1; i++) step0("t4_wait");
    enable[0] = 1'b0;
    step0("t4_cancel");
    enable[0] = 1'b1;
    for (int k = 0; k < 12; k++) step0("t4_cancel");

    // Drop on 2nd HIGH cycle: HIGH completes, then idle.
    for (int i = 0; i < 20 && ((c0 - 1) % p0) != 1; i++) step0("t4_wait");
    enable[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_hold_clk", clk_out[0], 1);
      check("t4_hold_run", running[0], 1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_stop_clk", clk_out[0], 0);
      check("t4_stop_run", running[0], 0);
    end
    enable[0] = 1'b1; c0 = 0;
    for (int k = 0; k < 12; k++) step0("t4_restart");

    // Reconfigure mid-HIGH: current 5/5 period completes, then 1/3.
    for (int i = 0; i < 20 && ((c0 - 1) % p0) != 1; i++) step0("t3_wait");
    set_cfg(0, 4, 1, 0);
    step0("t3_wr");
    cfg_wr = 1'b0;
    for (int k = 0; k < 7; k++) step0("t3_old");
    p0 = 4; h0 = 1; c0 = 0;
    for (int k = 0; k < 12; k++) step0("t3_new");

    // Rejected writes pulse cfg_err once and leave ch0 untouched.
    for (int i = 0; i < 4; i++) begin
      set_cfg(CHW'(bad_ch[i]), bad_p[i], bad_h[i], bad_d[i]);
      step0("t5_ch0");
      check("t5_err_hi", cfg_err, 1);
      cfg_wr = 1'b0;
      step0("t5_ch0");
      check("t5_err_lo", cfg_err, 0);
    end
    for (int k = 0; k < 8; k++) step0("t5_after");

    // Asynchronous reset in the middle of a HIGH cycle.
    for (int i = 0; i < 8 && exp0() != 1'b1; i++) step0("t6_wait");
    check("t6_pre_clk", clk_out[0], 1);
    #2 rst_n = 1'b0;
    enable = '0;
    #1;
    check("t6_async_clk", clk_out, 0);
    check("t6_async_run", running, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("t6_idle_clk", clk_out, 0);
    check("t6_idle_run", running, 0);
    enable = 3'b011; c0 = 0; p0 = 10; h0 = 5;
    for (int k = 0; k < 12; k++) begin
      step0("t6_ch0");
      check("t6_ch1", clk_out[1], exp0());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
